aes_host_ctrl: RTL and testbench

- Initiator-side sequencer for the AES core. It drives the core's run/keygen/mode/enc/key/data pins and consumes its ready/done/result.
- Accepts a 128-bit block stream on a valid/ready input and returns processed blocks on a valid/ready output.
- Handles key-schedule generation, optional CBC chaining, and a watchdog on the core's done response.
- Sits between the bus/DMA front end and the AES core.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_chain_unit.sv | 67 ++++++
 rtl/aes_host_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aes_host_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  aes_pkg
//  Shared widths, FSM state encoding and key-size mode codes for the AES
//  host-side sequencer.
//  Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 256;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_KG_REQ  = 3'd1;
    localparam state_t ST_KG_WAIT = 3'd2;
    localparam state_t ST_READY   = 3'd3;
    localparam state_t ST_RUN     = 3'd4;
    localparam state_t ST_WAIT    = 3'd5;
    localparam state_t ST_OUT     = 3'd6;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;

    function automatic logic is_busy_state(input state_t s);
        return !((s == ST_IDLE) || (s == ST_READY));
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_chain_unit.sv
`default_nettype none
// ============================================================================
//  aes_chain_unit
//  CBC chaining datapath: chain/ciphertext hold registers, the block presented
//  to the core and the result register with their XOR muxes.
//  Revision: 1.0
// ============================================================================
module aes_chain_unit
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_iv_load,
    input  logic [BLK_W-1:0] i_iv,
    input  logic             i_blk_load,
    input  logic [BLK_W-1:0] i_blk,
    input  logic             i_done_cap,
    input  logic [BLK_W-1:0] i_core_out,
    input  logic             i_enc,
    input  logic             i_cbc,
    output logic [BLK_W-1:0] o_core_in,
    output logic [BLK_W-1:0] o_out_data
);

    logic [BLK_W-1:0] chain_q,    chain_d;
    logic [BLK_W-1:0] ct_hold_q,  ct_hold_d;
    logic [BLK_W-1:0] core_in_q,  core_in_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;

    always_comb begin
        chain_d    = chain_q;
        ct_hold_d  = ct_hold_q;
        core_in_d  = core_in_q;
        out_data_d = out_data_q;
        if (i_iv_load) begin
            chain_d = i_iv;
        end else if (i_blk_load) begin
            core_in_d = (i_enc && i_cbc) ? (i_blk ^ chain_q) : i_blk;
            if (!i_enc && i_cbc) begin
                ct_hold_d = i_blk;
            end
        end else if (i_done_cap) begin
            out_data_d = (!i_enc && i_cbc) ? (i_core_out ^ chain_q) : i_core_out;
            // Next chaining value is always the ciphertext of this block.
            chain_d    = i_enc ? i_core_out : ct_hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q    <= '0;
            ct_hold_q  <= '0;
            core_in_q  <= '0;
            out_data_q <= '0;
        end else begin
            chain_q    <= chain_d;
            ct_hold_q  <= ct_hold_d;
            core_in_q  <= core_in_d;
            out_data_q <= out_data_d;
        end
    end

    assign o_core_in  = core_in_q;
    assign o_out_data = out_data_q;

endmodule
`default_nettype wire

// File: rtl/aes_host_ctrl.sv
`default_nettype none
// ============================================================================
//  aes_host_ctrl
//  Initiator-side sequencer for the AES core: key schedule, block streaming
//  with optional CBC chaining, and a watchdog on the core's done response.
//  Revision: 1.0
// ============================================================================
module aes_host_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_enc,
    input  logic             cfg_cbc,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err,
    output logic [KEY_W-1:0] core_key,
    output logic [1:0]       core_mode,
    output logic             core_enc,
    output logic             core_keygen,
    output logic             core_run,
    output logic [BLK_W-1:0] core_in,
    input  logic [BLK_W-1:0] core_out,
    input  logic             core_ready,
    input  logic             core_done
);

    localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT_CYCLES);

    state_t           state_q,    state_d;
    logic [KEY_W-1:0] key_q,      key_d;
    logic [1:0]       mode_q,     mode_d;
    logic             enc_q,      enc_d;
    logic             cbc_q,      cbc_d;
    logic             err_q,      err_d;
    logic [TW-1:0]    cnt_q,      cnt_d;
    logic             run_q,      run_d;
    logic             in_rdy_q,   in_rdy_d;
    logic             out_vld_q,  out_vld_d;
    logic             busy_q,     busy_d;
    logic             keygen_q,   keygen_d;

    logic w_cfg_take;
    logic w_blk_take;
    logic w_done_cap;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        mode_d     = mode_q;
        enc_d      = enc_q;
        cbc_d      = cbc_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        run_d      = 1'b0;
        w_done_cap = 1'b0;
        w_cfg_take = cfg_load && ((state_q == ST_IDLE) || (state_q == ST_READY));
        w_blk_take = in_valid && in_ready;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (w_cfg_take) begin
                    key_d   = cfg_key;
                    mode_d  = cfg_mode;
                    enc_d   = cfg_enc;
                    cbc_d   = cfg_cbc;
                    err_d   = 1'b0;
                    state_d = ST_KG_REQ;
                end else if (w_blk_take) begin
                    state_d = ST_RUN;
                end
            end
            ST_KG_REQ, ST_RUN: begin
                if (core_ready) begin
                    run_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = (state_q == ST_KG_REQ) ? ST_KG_WAIT : ST_WAIT;
                end
            end
            ST_KG_WAIT, ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done in the last cycle before expiry still wins.
                if (core_done) begin
                    w_done_cap = (state_q == ST_WAIT);
                    state_d    = (state_q == ST_KG_WAIT) ? ST_READY : ST_OUT;
                end else if (cnt_d == C_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_rdy_d  = (state_d == ST_READY);
        out_vld_d = (state_d == ST_OUT);
        busy_d    = is_busy_state(state_d);
        keygen_d  = (state_d == ST_KG_REQ) || (state_d == ST_KG_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            mode_q    <= '0;
            enc_q     <= 1'b0;
            cbc_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            keygen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            mode_q    <= mode_d;
            enc_q     <= enc_d;
            cbc_q     <= cbc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
            keygen_q  <= keygen_d;
        end
    end

    aes_chain_unit u_chain (
        .clk        (clk),
        .rst        (rst),
        .i_iv_load  (w_cfg_take),
        .i_iv       (cfg_iv),
        .i_blk_load (w_blk_take),
        .i_blk      (in_data),
        .i_done_cap (w_done_cap),
        .i_core_out (core_out),
        .i_enc      (enc_q),
        .i_cbc      (cbc_q),
        .o_core_in  (core_in),
        .o_out_data (out_data)
    );

    // A cfg_load in READY pre-empts the block, so ready is withdrawn in that cycle.
    assign in_ready    = in_rdy_q & ~cfg_load;
    assign out_valid   = out_vld_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign core_key    = key_q;
    assign core_mode   = mode_q;
    assign core_enc    = enc_q;
    assign core_keygen = keygen_q;
    assign core_run    = run_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_host_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_aes_host_ctrl
//  Scoreboard bench: AES core model with known-answer vectors plus a keyed
//  bijection for random traffic; CBC reference kept at block level.
//  Revision: 1.0
// ============================================================================
module tb_aes_host_ctrl;

    localparam logic [255:0] K_FIPS = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K_SP   = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [127:0] IV_SP  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2     = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] X1     = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] X2     = 128'hd86421fb9f1a1eda505ee1375746972c;

    logic         clk, rst, cfg_load, cfg_enc, cfg_cbc, in_valid, in_ready;
    logic [255:0] cfg_key, core_key;
    logic [1:0]   cfg_mode, core_mode;
    logic [127:0] cfg_iv, in_data, out_data, core_in, core_out;
    logic         out_valid, out_ready, busy, err, core_enc, core_keygen, core_run;
    logic         core_ready, core_done;

    aes_host_ctrl #(.TIMEOUT_CYCLES(255), .TW(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_mode(cfg_mode),
        .cfg_enc(cfg_enc), .cfg_cbc(cfg_cbc), .cfg_iv(cfg_iv), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err(err), .core_key(core_key),
        .core_mode(core_mode), .core_enc(core_enc), .core_keygen(core_keygen),
        .core_run(core_run), .core_in(core_in), .core_out(core_out),
        .core_ready(core_ready), .core_done(core_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [127:0] exp_q[$];

    // reference-model state (what the host should be doing, block by block)
    logic [255:0] r_key;
    logic [1:0]   r_mode;
    logic         r_enc, r_cbc;
    logic [127:0] r_chain;

    // core-model controls
    bit cm_hang    = 0;
    int cm_blk_lat = 0;
    bit rdy_rand   = 0;
    bit rdy_force  = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] tweak(input logic [255:0] k, input logic [1:0] m);
        return k[255:128] ^ {126'd0, m};
    endfunction

    // Block cipher as seen by the host: published AES answers, else a keyed bijection.
    function automatic logic [127:0] cipher(input logic e, input logic [255:0] k,
                                            input logic [1:0] m, input logic [127:0] x);
        logic [127:0] t;
        if (e) begin
            if (k == K_FIPS && x == P_FIPS) return C_FIPS;
            if (k == K_SP && x == X1) return C1;
            if (k == K_SP && x == X2) return C2;
            t = x ^ k[127:0];
            return {t[114:0], t[127:115]} + tweak(k, m);
        end else begin
            if (k == K_FIPS && x == C_FIPS) return P_FIPS;
            if (k == K_SP && x == C1) return X1;
            if (k == K_SP && x == C2) return X2;
            t = x - tweak(k, m);
            return {t[12:0], t[127:13]} ^ k[127:0];
        end
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Core model: learns the key during keygen, answers each run after a latency.
    initial begin : core_model
        logic [255:0] cm_key;
        logic [127:0] cm_res;
        bit           cm_busy;
        int           cm_cnt;
        cm_key = '0; cm_res = '0; cm_busy = 0; cm_cnt = 0;
        core_ready = 1; core_done = 0; core_out = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 0;
            if (cm_busy) begin
                if (cm_cnt <= 1) begin
                    core_done = 1; core_out = cm_res; cm_busy = 0; core_ready = 1;
                end else begin
                    cm_cnt--;
                end
            end else if (core_run) begin
                if (core_keygen) cm_key = core_key;
                else cm_res = cipher(core_enc, cm_key, core_mode, core_in);
                cm_busy = 1; core_ready = 0;
                if (cm_hang) cm_cnt = 400;
                else if (core_keygen) cm_cnt = 12;
                else if (cm_blk_lat != 0) cm_cnt = cm_blk_lat;
                else cm_cnt = $urandom_range(1, 8);
            end
        end
    end

    initial begin : ready_driver
        out_ready = 0;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks hold during stalls.
    initial begin : monitor
        bit           hold;
        logic [127:0] held;
        hold = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!out_valid || out_data !== held) begin
                        errors++;
                        $display("FAIL out_hold: got valid=%0b data=%h required valid=1 data=%h",
                                 out_valid, out_data, held);
                    end
                end
                if (out_valid && out_ready) begin
                    hold = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: got %h required no output", out_data);
                    end else begin
                        logic [127:0] e;
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL out_data: got %h required %h", out_data, e);
                        end
                    end
                end else if (out_valid) begin
                    hold = 1; held = out_data;
                end else begin
                    hold = 0;
                end
            end
        end
    end

    task automatic do_cfg(input logic [255:0] k, input logic [1:0] m, input logic e,
                          input logic c, input logic [127:0] iv);
        @(posedge clk); #1;
        cfg_key = k; cfg_mode = m; cfg_enc = e; cfg_cbc = c; cfg_iv = iv; cfg_load = 1;
        @(posedge clk); #1;
        cfg_load = 0;
        r_key = k; r_mode = m; r_enc = e; r_cbc = c; r_chain = iv;
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk(name, ok, 1);
    endtask

    task automatic send(input logic [127:0] d);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        in_data = d; in_valid = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 0;
        if (!ok) chk("send_timeout", ok, 1);
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d);
        logic [127:0] res;
        if (r_enc) begin
            res = cipher(1'b1, r_key, r_mode, r_cbc ? (d ^ r_chain) : d);
            if (r_cbc) r_chain = res;
        end else begin
            res = cipher(1'b0, r_key, r_mode, d);
            if (r_cbc) begin res = res ^ r_chain; r_chain = d; end
        end
        return res;
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin : stim
        int t_run, t_err;
        bit saw_ov;
        logic [127:0] d, iv;
        rst = 1; cfg_load = 0; cfg_key = '0; cfg_mode = '0; cfg_enc = 0; cfg_cbc = 0;
        cfg_iv = '0; in_data = '0; in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {in_ready, out_valid, busy, err, core_run, core_keygen, core_enc, core_mode}, 0);
        chk("reset_core_key", core_key, 0);
        chk("reset_core_in", core_in, 0);
        chk("reset_out_data", out_data, 0);
        @(posedge clk); #1 rst = 0;

        // FIPS-197 ECB encrypt
        do_cfg(K_FIPS, 2'b00, 1, 0, '0);
        @(negedge clk);
        chk("kg_phase", {busy, core_keygen, in_ready}, 3'b110);
        chk("core_key", core_key, K_FIPS);
        wait_ready("kg_done", 100);
        chk("kg_off", core_keygen, 0);
        exp_q.push_back(C_FIPS); send(P_FIPS);
        drain("drain_fips");

        // SP800-38A CBC encrypt
        do_cfg(K_SP, 2'b00, 1, 1, IV_SP);
        wait_ready("kg_cbc_enc", 100);
        exp_q.push_back(C1); send(P1);
        exp_q.push_back(C2); send(P2);
        drain("drain_cbc_enc");

        // CBC decrypt with a 5-cycle output stall
        do_cfg(K_SP, 2'b00, 0, 1, IV_SP);
        wait_ready("kg_cbc_dec", 100);
        rdy_force = 0;
        exp_q.push_back(P1); send(C1);
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (out_valid) break; end
        repeat (5) @(negedge clk);
        chk("stall_valid", {out_valid, out_data}, {1'b1, P1});
        rdy_force = 1;
        exp_q.push_back(P2); send(C2);
        drain("drain_cbc_dec");

        // Randomized configurations with random backpressure and core latency
        rdy_rand = 1;
        for (int c = 0; c < 3; c++) begin
            do_cfg({rand128(), rand128()}, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rand128());
            wait_ready("kg_rand", 100);
            for (int b = 0; b < 5; b++) begin
                d = rand128();
                exp_q.push_back(ref_block(d));
                send(d);
            end
            drain("drain_rand");
        end
        rdy_rand = 0;

        // Watchdog: core never answers in time
        do_cfg(K_FIPS, 2'b00, 1, 0, '0);
        wait_ready("kg_wd", 100);
        cm_hang = 1;
        send(P_FIPS);
        t_run = -1000; t_err = 0; saw_ov = 0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (core_run) begin t_run = cyc; break; end end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1;
            if (err) begin t_err = cyc; break; end
        end
        cm_hang = 0;
        chk("wd_latency", 256'(t_err - t_run), 255);
        chk("wd_no_out", saw_ov, 0);
        chk("wd_idle", {busy, in_ready, out_valid}, 0);
        do_cfg(K_FIPS, 2'b00, 1, 0, '0);
        @(negedge clk);
        chk("err_clear", err, 0);
        wait_ready("kg_after_wd", 600);
        exp_q.push_back(C_FIPS); send(P_FIPS);
        drain("drain_after_wd");

        // cfg_load beats in_valid in READY; new IV must seed the chain
        do_cfg({rand128(), rand128()}, 2'b01, 1, 1, rand128());
        wait_ready("kg_pri_a", 100);
        @(posedge clk); #1;
        iv = rand128();
        cfg_key = {rand128(), rand128()}; cfg_mode = 2'b10; cfg_enc = 1; cfg_cbc = 1;
        cfg_iv = iv; cfg_load = 1; in_data = rand128(); in_valid = 1;
        @(negedge clk);
        chk("pri_in_ready", in_ready, 0);
        @(posedge clk); #1;
        cfg_load = 0; in_valid = 0;
        r_key = cfg_key; r_mode = cfg_mode; r_enc = 1; r_cbc = 1; r_chain = iv;
        @(negedge clk);
        chk("pri_keygen", {busy, core_keygen}, 2'b11);
        wait_ready("kg_pri_b", 100);
        d = rand128();
        exp_q.push_back(ref_block(d)); send(d);
        drain("drain_pri");

        // rst during WAIT drops the block; the late done is ignored
        do_cfg({rand128(), rand128()}, 2'b00, 1, 0, '0);
        wait_ready("kg_rst", 100);
        cm_blk_lat = 30;
        send(rand128());
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (core_run) break; end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_ctl", {in_ready, out_valid, busy, err, core_run, core_keygen, core_enc, core_mode}, 0);
        chk("rst_core_in", {core_key, core_in}, 0);
        saw_ov = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) saw_ov = 1; end
        chk("rst_late_done", {saw_ov, busy, out_data}, 0);
        cm_blk_lat = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_guard
        #600000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
